// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one memory request at a time,
// hands each fetched word to decode, and handles redirects, squash and halt.
module fetch_controller #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [31:0]     HALT_INSTR = 32'h0000_0033
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic [31:0]     instr_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            req_hs;
  logic [XLEN-1:0] redir_pc;

  assign req_hs        = mem_req_valid && mem_req_ready;
  assign redir_pc      = redirect_pc & ~XLEN'(3);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = pc_q;
  // A redirect kills the presented instruction in the same cycle.
  assign out_valid     = (state_q == S_HOLD) && !redirect_valid;
  assign out_pc        = out_pc_q;
  assign out_instr     = out_instr_q;
  assign halted        = (state_q == S_HALT);
  assign instr_count   = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_REQ: begin
        // Request accepted alongside a redirect: its response is stale.
        if (req_hs) begin
          state_d  = S_WAIT;
          squash_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          squash_d = 1'b0;
          if (squash_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_HOLD;
            out_instr_d = mem_rsp_data;
            out_pc_d    = pc_q;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + XLEN'(4);
          cnt_d   = cnt_q + 32'd1;
          state_d = (out_instr_q == HALT_INSTR) ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (redirect_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) pc_d = redir_pc;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: randomized memory/decode/redirect stimulus checked every
// cycle against an architectural-PC model, plus directed scenarios with literal values.
module tb_fetch_controller;

  localparam logic [31:0] HALT = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic [31:0] instr_count;

  fetch_controller dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] mem [256];

  // memory / decode knobs
  int  or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  int  rq_mode = 0;   // 0: mem_req_ready=1, 1: random
  int  lat = 0;       // extra wait cycles, <0 = random 0..3
  bit  rst_drop = 0;
  bit  pend = 0, hs_flag = 0;
  int  pcnt = 0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // one clock: drive inputs at negedge, act as memory, note request handshakes
  task automatic cyc(input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    if (rst_drop) begin reset = 1'b0; rst_drop = 0; end
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = (or_mode == 0) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom % 2);
    mem_req_ready  = (rq_mode == 0) ? 1'b1 : ($urandom % 3 != 0);
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = $urandom;
    if (reset) pend = 0;
    else if (pend) begin
      if (pcnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mword(paddr);
        pend = 0;
      end else pcnt--;
    end
    #1;
    hs_flag = !reset && mem_req_valid && mem_req_ready;
    if (hs_flag) begin
      pend  = 1;
      paddr = mem_req_addr;
      pcnt  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    end
  endtask

  task automatic wait_until(input int what);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc(1'b0, '0);
      case (what)
        0: ok = out_valid;
        1: ok = hs_flag;
        2: ok = halted;
        default: ok = mem_req_valid;
      endcase
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout_%0d act=none exp=event", what);
    end
  endtask

  // Architectural model: the PC of the next instruction to deliver, delivered count, halt flag.
  logic [31:0] mpc = '0, mcount = '0;
  bit          mhalted = 0;

  always @(negedge clk) begin
    #2;
    if (reset) begin
      mpc = '0; mcount = '0; mhalted = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_halted", halted, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
    end else begin
      chk("count", instr_count, mcount);
      chk("halted", halted, mhalted);
      if (mhalted) chk("halt_no_req", mem_req_valid, 0);
      if (redirect_valid || mhalted) chk("out_gate", out_valid, 0);
      if (mem_req_valid) chk("req_addr", mem_req_addr, mpc);
      if (out_valid) begin
        chk("out_pc", out_pc, mpc);
        chk("out_instr", out_instr, mword(mpc));
      end
      if (redirect_valid) begin
        mpc = redirect_pc & ~32'd3;
        mhalted = 0;
      end else if (out_valid && out_ready) begin
        mcount++;
        if (mword(mpc) == HALT) mhalted = 1;
        mpc = mpc + 32'd4;
      end
    end
  end

  logic [31:0] pcs [$];
  logic [31:0] c0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = w ^ 32'h100;
      if (i >= 70 && i != 255 && $urandom % 12 == 0) w = HALT;
      mem[i] = w;
    end
    mem[0] = 32'h0010_80B3;  // add x1,x1,x1
    mem[1] = 32'h0020_8133;  // add x2,x1,x2
    mem[2] = HALT;
    mem[128] = HALT;

    repeat (3) cyc(1'b0, '0);

    // 1: zero-wait memory, ADD/ADD/HALT
    rst_drop = 1;
    for (int k = 0; k < 15; k++) begin
      cyc(1'b0, '0);
      if (k == 0) begin
        chk("t1_first_req", mem_req_valid, 1);
        chk("t1_first_addr", mem_req_addr, 32'h0);
      end
      if (k < 2) chk("t1_lat_early", out_valid, 0);
      if (k == 2) chk("t1_lat_valid", out_valid, 1);
      if (k >= 9) chk("t1_halt_noreq", mem_req_valid, 0);
      if (out_valid && out_ready) pcs.push_back(out_pc);
    end
    chk("t1_ndeliv", pcs.size(), 3);
    if (pcs.size() == 3) begin
      chk("t1_pc0", pcs[0], 32'h0);
      chk("t1_pc1", pcs[1], 32'h4);
      chk("t1_pc2", pcs[2], 32'h8);
    end
    chk("t1_halted", halted, 1);
    chk("t1_count", instr_count, 3);

    // 2: decode back-pressure while holding
    or_mode = 2;
    cyc(1'b1, 32'h10);
    wait_until(0);
    chk("t2_pc", out_pc, 32'h10);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0);
      chk("t2_pc_stable", out_pc, 32'h10);
      chk("t2_instr_stable", out_instr, mem[4]);
      chk("t2_no_req", mem_req_valid, 0);
    end
    or_mode = 0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("t2_next_req", mem_req_valid, 1);
    chk("t2_next_addr", mem_req_addr, 32'h14);

    // 3: redirect while waiting on a 3-cycle memory
    lat = 3;
    wait_until(1);
    cyc(1'b1, 32'h42);
    wait_until(3);
    chk("t3_req_addr", mem_req_addr, 32'h40);
    wait_until(0);
    chk("t3_out_pc", out_pc, 32'h40);
    chk("t3_out_instr", out_instr, mem[16]);

    // 4: redirect coincident with response, then redirect in hold
    lat = 0; or_mode = 2;
    wait_until(1);
    c0 = instr_count;
    cyc(1'b1, 32'h80);
    cyc(1'b0, '0);
    chk("t4_count_rsp", instr_count, c0);
    chk("t4_req_addr", mem_req_addr, 32'h80);
    wait_until(0);
    chk("t4_hold_pc", out_pc, 32'h80);
    or_mode = 0;
    cyc(1'b1, 32'hC0);
    chk("t4_gated", out_valid, 0);
    cyc(1'b0, '0);
    chk("t4_count_hold", instr_count, c0);
    chk("t4_req_addr2", mem_req_addr, 32'hC0);

    // 5: resume from halt
    cyc(1'b1, 32'h200);
    wait_until(2);
    cyc(1'b1, 32'h100);
    cyc(1'b0, '0);
    chk("t5_halted", halted, 0);
    chk("t5_req", mem_req_valid, 1);
    chk("t5_addr", mem_req_addr, 32'h100);

    // 6: PC wrap, then async reset mid-wait
    cyc(1'b1, 32'hFFFF_FFFF);
    wait_until(0);
    chk("t6_top_pc", out_pc, 32'hFFFF_FFFC);
    cyc(1'b0, '0);
    chk("t6_wrap_addr", mem_req_addr, 32'h0);
    lat = 3;
    wait_until(1);
    cyc(1'b0, '0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pc", mem_req_addr, 32'h0);
    chk("t6_rst_count", instr_count, 0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    rst_drop = 1;
    wait_until(0);
    chk("t6_after_rst_pc", out_pc, 32'h0);

    // randomized traffic
    lat = -1; rq_mode = 1; or_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      bit rv;
      logic [31:0] t;
      rv = ($urandom % 20 == 0);
      t  = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom % 1024);
      cyc(rv, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
